// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared constants for the pipelined barrel shifter: operation and direction
// codes plus the latency calculation used by the top and its users.
package shifter_pkg;

    localparam logic [1:0] SH_NS = 2'd0;
    localparam logic [1:0] SH_LO = 2'd1;
    localparam logic [1:0] SH_AR = 2'd2;
    localparam logic [1:0] SH_RO = 2'd3;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

    // One register stage per group of pipe_every mux levels, last group may be partial.
    function automatic int calc_lat(input int width, input int pipe_every);
        int log2w;
        log2w = $clog2(width);
        return (log2w + pipe_every - 1) / pipe_every;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result bus of the pipelined barrel shifter; the shifter is the slave,
// the issuing execute stage is the master.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
);
    localparam int LOG2W = $clog2(WIDTH);

    // Both sides: a beat transfers on a rising edge where valid && ready; the
    // producer keeps its payload stable and valid high until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LOG2W-1:0] in_ct;
    logic             in_dir;
    logic [1:0]       in_type;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_ct, in_dir, in_type, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_ct, in_dir, in_type, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_tag
    );

endinterface

// File: rtl/pipelined_barrel_shifter_shift_level.sv
// One combinational mux level of the barrel shifter: shifts by the fixed
// amount SHIFT when en is set, otherwise passes the data through.
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             sign,
    input  logic             dir,
    input  logic [1:0]       typ,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        if (en && typ != SH_NS) begin
            if (dir == DIR_L) begin
                if (typ == SH_RO) q = {d[WIDTH-SHIFT-1:0], d[WIDTH-1:WIDTH-SHIFT]};
                else              q = {d[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
            end else begin
                // Arithmetic fill uses the original operand's sign, not this level's MSB.
                if (typ == SH_RO) q = {d[SHIFT-1:0], d[WIDTH-1:SHIFT]};
                else              q = {{SHIFT{sign & (typ == SH_AR)}}, d[WIDTH-1:SHIFT]};
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: LOG2W mux levels with a register after every
// PIPE_EVERY levels, global stall on backpressure, carry-out, zero flag and tag.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 5
) (
    input logic                      clk,
    input logic                      rst,
    pipelined_barrel_shifter_if.slave bus
);

    localparam int LOG2W = $clog2(WIDTH);
    localparam int LAT   = calc_lat(WIDTH, PIPE_EVERY);

    logic en;
    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    // Carry is fully determined by the original operand, so it is resolved at
    // entry and travels with the data; for rotates it equals the wrapped bit.
    logic [LOG2W-1:0] lidx, ridx;
    logic             carry_in;
    assign lidx = ~bus.in_ct + LOG2W'(1);
    assign ridx = bus.in_ct - LOG2W'(1);

    always_comb begin
        carry_in = 1'b0;
        if (bus.in_type != SH_NS && bus.in_ct != '0)
            carry_in = (bus.in_dir == DIR_L) ? bus.in_data[lidx] : bus.in_data[ridx];
    end

    logic             st_valid [LAT];
    logic [WIDTH-1:0] st_data  [LAT];
    logic [LOG2W-1:0] st_ct    [LAT];
    logic             st_dir   [LAT];
    logic             st_sign  [LAT];
    logic             st_carry [LAT];
    logic [1:0]       st_type  [LAT];
    logic [TAG_W-1:0] st_tag   [LAT];
    logic             st_zero;

    logic             g_valid [LAT];
    logic [WIDTH-1:0] g_data  [LAT];
    logic [LOG2W-1:0] g_ct    [LAT];
    logic             g_dir   [LAT];
    logic             g_sign  [LAT];
    logic             g_carry [LAT];
    logic [1:0]       g_type  [LAT];
    logic [TAG_W-1:0] g_tag   [LAT];
    logic [WIDTH-1:0] stage_d [LAT];
    logic [WIDTH-1:0] lvl_out [LOG2W];

    for (genvar g = 0; g < LAT; g++) begin : g_stage
        localparam int LAST = ((g + 1) * PIPE_EVERY > LOG2W) ? LOG2W - 1 : (g + 1) * PIPE_EVERY - 1;
        if (g == 0) begin : g_src_in
            assign g_valid[g] = bus.in_valid;
            assign g_data[g]  = bus.in_data;
            assign g_ct[g]    = bus.in_ct;
            assign g_dir[g]   = bus.in_dir;
            assign g_sign[g]  = bus.in_data[WIDTH-1];
            assign g_carry[g] = carry_in;
            assign g_type[g]  = bus.in_type;
            assign g_tag[g]   = bus.in_tag;
        end else begin : g_src_reg
            assign g_valid[g] = st_valid[g-1];
            assign g_data[g]  = st_data[g-1];
            assign g_ct[g]    = st_ct[g-1];
            assign g_dir[g]   = st_dir[g-1];
            assign g_sign[g]  = st_sign[g-1];
            assign g_carry[g] = st_carry[g-1];
            assign g_type[g]  = st_type[g-1];
            assign g_tag[g]   = st_tag[g-1];
        end
        assign stage_d[g] = lvl_out[LAST];
    end

    for (genvar i = 0; i < LOG2W; i++) begin : g_level
        localparam int G = i / PIPE_EVERY;
        logic [WIDTH-1:0] lvl_in;
        if (i % PIPE_EVERY == 0) begin : g_from_stage
            assign lvl_in = g_data[G];
        end else begin : g_from_level
            assign lvl_in = lvl_out[i-1];
        end
        shift_level #(.WIDTH(WIDTH), .SHIFT(1 << i)) u_level (
            .d    (lvl_in),
            .sign (g_sign[G]),
            .dir  (g_dir[G]),
            .typ  (g_type[G]),
            .en   (g_ct[G][i]),
            .q    (lvl_out[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < LAT; g++) begin
                st_valid[g] <= 1'b0;
                st_data[g]  <= '0;
                st_ct[g]    <= '0;
                st_dir[g]   <= 1'b0;
                st_sign[g]  <= 1'b0;
                st_carry[g] <= 1'b0;
                st_type[g]  <= '0;
                st_tag[g]   <= '0;
            end
            st_zero <= 1'b0;
        end else if (en) begin
            for (int g = 0; g < LAT; g++) begin
                st_valid[g] <= g_valid[g];
                st_data[g]  <= stage_d[g];
                st_ct[g]    <= g_ct[g];
                st_dir[g]   <= g_dir[g];
                st_sign[g]  <= g_sign[g];
                st_carry[g] <= g_carry[g];
                st_type[g]  <= g_type[g];
                st_tag[g]   <= g_tag[g];
            end
            st_zero <= (stage_d[LAT-1] == '0);
        end
    end

    assign bus.out_valid = st_valid[LAT-1];
    assign bus.out_data  = st_data[LAT-1];
    assign bus.out_carry = st_carry[LAT-1];
    assign bus.out_zero  = st_zero;
    assign bus.out_tag   = st_tag[LAT-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: an 8-bit PIPE_EVERY=1 instance for directed,
// backpressure and reset cases, and four 64-bit instances for a random sweep.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- 8-bit instance ----------------
    pipelined_barrel_shifter_if #(.WIDTH(8), .TAG_W(5)) bus8 ();
    pipelined_barrel_shifter #(.WIDTH(8), .PIPE_EVERY(1), .TAG_W(5)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    // ---------------- 64-bit instances, shared stimulus ----------------
    logic        r_valid;
    logic [63:0] r_data;
    logic [5:0]  r_ct;
    logic        r_dir;
    logic [1:0]  r_type;
    logic [4:0]  r_tag;

    logic        o_valid [4];
    logic        o_ready [4];
    logic        o_carry [4];
    logic        o_zero  [4];
    logic [63:0] o_data  [4];
    logic [4:0]  o_tag   [4];

    int lat_tab [4] = '{6, 3, 2, 1};

    for (genvar k = 0; k < 4; k++) begin : g64
        localparam int PE = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 3 : 6;
        pipelined_barrel_shifter_if #(.WIDTH(64), .TAG_W(5)) bus ();
        pipelined_barrel_shifter #(.WIDTH(64), .PIPE_EVERY(PE), .TAG_W(5)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign bus.in_valid  = r_valid;
        assign bus.in_data   = r_data;
        assign bus.in_ct     = r_ct;
        assign bus.in_dir    = r_dir;
        assign bus.in_type   = r_type;
        assign bus.in_tag    = r_tag;
        assign bus.out_ready = 1'b1;
        assign o_valid[k] = bus.out_valid;
        assign o_ready[k] = bus.in_ready;
        assign o_carry[k] = bus.out_carry;
        assign o_zero[k]  = bus.out_zero;
        assign o_data[k]  = bus.out_data;
        assign o_tag[k]   = bus.out_tag;
    end

    // ---------------- reference model ----------------
    // Applies the shift as ct repeated single-bit steps; carry is the last bit
    // pushed out. Returns {zero, carry, data}.
    function automatic logic [65:0] ref_model(input logic [63:0] d_in, input int ct,
                                              input logic dir, input logic [1:0] typ,
                                              input int w);
        logic [63:0] mask, d;
        logic        c, msb;
        mask = {64{1'b1}} >> (64 - w);
        d    = d_in & mask;
        c    = 1'b0;
        if (typ != SH_NS) begin
            for (int i = 0; i < ct; i++) begin
                if (dir == DIR_L) begin
                    c = d[w-1];
                    d = ((d << 1) & mask) | ((typ == SH_RO) ? 64'(c) : 64'd0);
                end else begin
                    c   = d[0];
                    msb = (typ == SH_RO) ? c : (typ == SH_AR) ? d[w-1] : 1'b0;
                    d   = (d >> 1) | (64'(msb) << (w - 1));
                end
            end
        end
        return {(d == 64'd0), c, d};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle8();
        bus8.in_valid = 1'b0;
        bus8.in_data  = '0;
        bus8.in_ct    = '0;
        bus8.in_dir   = 1'b0;
        bus8.in_type  = '0;
        bus8.in_tag   = '0;
    endtask

    // Pushes one operand into an empty 8-bit pipe and waits for its result.
    task automatic run_one8(input logic [7:0] d, input logic [2:0] ct, input logic dir,
                            input logic [1:0] typ, input logic [4:0] tag,
                            output logic [7:0] od, output logic oc, output logic oz,
                            output logic [4:0] ot, output int lat);
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.in_data   = d;
        bus8.in_ct     = ct;
        bus8.in_dir    = dir;
        bus8.in_type   = typ;
        bus8.in_tag    = tag;
        step();
        idle8();
        lat = 1;
        while (!bus8.out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!bus8.out_valid) lat = -1;
        od = bus8.out_data;
        oc = bus8.out_carry;
        oz = bus8.out_zero;
        ot = bus8.out_tag;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst     = 1'b1;
        idle8();
        bus8.out_ready = 1'b1;
        r_valid = 1'b0;
        r_data  = '0;
        r_ct    = '0;
        r_dir   = 1'b0;
        r_type  = '0;
        r_tag   = '0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({bus8.out_valid, bus8.out_data, bus8.out_carry, bus8.out_zero, bus8.out_tag} !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%b z=%b t=%0d, expected all zero",
                     bus8.out_valid, bus8.out_data, bus8.out_carry, bus8.out_zero, bus8.out_tag);
        end
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus8.in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_valid[k] !== 1'b0 || o_data[k] !== 64'd0) begin
                errors++;
                $display("FAIL reset_w64[%0d]: got v=%b d=%h expected v=0 d=0", k, o_valid[k], o_data[k]);
            end
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic [2:0] ct;
        logic       dir;
        logic [1:0] typ;
        logic [4:0] tag;
        logic [7:0] ed;
        logic       ec;
        logic       ez;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[4];
        logic [7:0] od;
        logic oc, oz;
        logic [4:0] ot;
        int lat;
        vecs[0] = '{8'hB4, 3'd3, DIR_R, SH_AR, 5'd7, 8'hF6, 1'b1, 1'b0};
        vecs[1] = '{8'h81, 3'd1, DIR_L, SH_RO, 5'd1, 8'h03, 1'b1, 1'b0};
        vecs[2] = '{8'h81, 3'd1, DIR_L, SH_LO, 5'd2, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 3'd1, DIR_R, SH_LO, 5'd3, 8'h00, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_one8(vecs[i].d, vecs[i].ct, vecs[i].dir, vecs[i].typ, vecs[i].tag, od, oc, oz, ot, lat);
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected 3", i, lat);
            end
            checks++;
            if (od !== vecs[i].ed || oc !== vecs[i].ec || oz !== vecs[i].ez || ot !== vecs[i].tag) begin
                errors++;
                $display("FAIL directed[%0d]: got d=%h c=%b z=%b t=%0d expected d=%h c=%b z=%b t=%0d",
                         i, od, oc, oz, ot, vecs[i].ed, vecs[i].ec, vecs[i].ez, vecs[i].tag);
            end
        end
    endtask

    task automatic test_ct_zero();
        logic [7:0] od;
        logic oc, oz;
        logic [4:0] ot;
        int lat;
        for (int t = 0; t < 5; t++) begin
            logic [1:0] typ;
            logic [2:0] ct;
            typ = (t < 4) ? 2'(t) : SH_NS;
            ct  = (t < 4) ? 3'd0 : 3'd5;
            run_one8(8'h5A, ct, 1'($urandom_range(0, 1)), typ, 5'(t + 10), od, oc, oz, ot, lat);
            checks++;
            if (od !== 8'h5A || oc !== 1'b0 || oz !== 1'b0 || ot !== 5'(t + 10) || lat !== 3) begin
                errors++;
                $display("FAIL ct_zero_ns[%0d]: got d=%h c=%b z=%b t=%0d lat=%0d expected d=5a c=0 z=0 t=%0d lat=3",
                         t, od, oc, oz, ot, lat, t + 10);
            end
        end
    endtask

    task automatic test_max_ct();
        logic [7:0] od, d;
        logic oc, oz, dir;
        logic [1:0] typ;
        logic [4:0] ot;
        logic [65:0] e;
        int lat;
        for (int i = 0; i < 8; i++) begin
            d   = 8'($urandom);
            dir = 1'(i & 1);
            typ = 2'($urandom_range(1, 3));
            e   = ref_model({56'd0, d}, 7, dir, typ, 8);
            run_one8(d, 3'd7, dir, typ, 5'(i), od, oc, oz, ot, lat);
            checks++;
            if (od !== e[7:0] || oc !== e[64] || oz !== e[65] || ot !== 5'(i)) begin
                errors++;
                $display("FAIL max_ct[%0d] d=%h dir=%b typ=%0d: got d=%h c=%b z=%b t=%0d expected d=%h c=%b z=%b t=%0d",
                         i, d, dir, typ, od, oc, oz, ot, e[7:0], e[64], e[65], i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [14:0] exp_q[$];
        logic [2:0]  ct_a  [10];
        logic        dir_a [10];
        logic [1:0]  typ_a [10];
        logic [14:0] got, exp, held;
        logic        hold, fire_in, fire_out;
        logic [65:0] e;
        int sent, recv, occ, cyc;
        for (int i = 0; i < 10; i++) begin
            ct_a[i]  = 3'($urandom);
            dir_a[i] = 1'($urandom);
            typ_a[i] = 2'($urandom);
        end
        sent = 0; recv = 0; occ = 0; cyc = 0; hold = 1'b0; held = '0;
        while (recv < 10 && cyc < 300) begin
            got = {bus8.out_tag, bus8.out_carry, bus8.out_zero, bus8.out_data};
            if (hold) begin
                checks++;
                if ({bus8.out_valid, got} !== {1'b1, held}) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b %h expected v=1 %h", bus8.out_valid, got, held);
                end
            end
            bus8.out_ready = 1'($urandom_range(0, 1));
            if (sent < 10) begin
                bus8.in_valid = 1'b1;
                bus8.in_data  = 8'(sent + 1);
                bus8.in_ct    = ct_a[sent];
                bus8.in_dir   = dir_a[sent];
                bus8.in_type  = typ_a[sent];
                bus8.in_tag   = 5'(sent + 1);
            end else begin
                idle8();
            end
            #1;
            if (occ == 3 && !bus8.out_ready) begin
                checks++;
                if (bus8.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_stall_in_ready: got %b expected 0", bus8.in_ready);
                end
            end
            fire_in  = bus8.in_valid && bus8.in_ready;
            fire_out = bus8.out_valid && bus8.out_ready;
            if (fire_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_unexpected: got %h with nothing outstanding", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL bp_result: got %h expected %h", got, exp);
                    end
                end
                recv++;
            end
            if (fire_in) begin
                e = ref_model(64'(sent + 1), int'(ct_a[sent]), dir_a[sent], typ_a[sent], 8);
                exp_q.push_back({5'(sent + 1), e[64], e[65], e[7:0]});
                sent++;
            end
            occ  = occ + int'(fire_in) - int'(fire_out);
            hold = bus8.out_valid && !bus8.out_ready;
            held = got;
            step();
            cyc++;
        end
        checks++;
        if (recv != 10 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_complete: got %0d results (%0d pending) expected 10 (0)", recv, exp_q.size());
        end
        idle8();
        bus8.out_ready = 1'b1;
        step();
        step();
        step();
        step();
    endtask

    task automatic test_reset_flush();
        bus8.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus8.in_valid = 1'b1;
            bus8.in_data  = 8'($urandom_range(1, 255));
            bus8.in_ct    = 3'($urandom);
            bus8.in_dir   = 1'($urandom);
            bus8.in_type  = 2'($urandom);
            bus8.in_tag   = 5'(20 + i);
            step();
        end
        idle8();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus8.out_valid, bus8.out_data, bus8.out_carry, bus8.out_zero, bus8.out_tag} !== 16'd0) begin
            errors++;
            $display("FAIL flush_outputs: got v=%b d=%h c=%b z=%b t=%0d expected all zero",
                     bus8.out_valid, bus8.out_data, bus8.out_carry, bus8.out_zero, bus8.out_tag);
        end
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_ready: got %b expected 1", bus8.in_ready);
        end
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus8.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost[%0d]: got out_valid=%b tag=%0d expected 0", i, bus8.out_valid, bus8.out_tag);
            end
        end
    endtask

    typedef struct {
        logic [63:0] d;
        logic        c;
        logic        z;
        logic [4:0]  t;
        int          cyc;
    } e64_t;

    task automatic test_random_sweep();
        e64_t q64[4][$];
        e64_t e;
        logic [65:0] m;
        for (int n = 0; n < 420; n++) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (o_ready[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_in_ready[%0d]: got %b expected 1", k, o_ready[k]);
                end
                if (o_valid[k] === 1'b1) begin
                    checks++;
                    if (q64[k].size() == 0) begin
                        errors++;
                        $display("FAIL sweep_unexpected[%0d]: got d=%h with nothing outstanding", k, o_data[k]);
                    end else begin
                        e = q64[k].pop_front();
                        if (o_data[k] !== e.d || o_carry[k] !== e.c || o_zero[k] !== e.z || o_tag[k] !== e.t) begin
                            errors++;
                            $display("FAIL sweep_result[%0d]: got d=%h c=%b z=%b t=%0d expected d=%h c=%b z=%b t=%0d",
                                     k, o_data[k], o_carry[k], o_zero[k], o_tag[k], e.d, e.c, e.z, e.t);
                        end
                        checks++;
                        if (n - e.cyc != lat_tab[k]) begin
                            errors++;
                            $display("FAIL sweep_latency[%0d]: got %0d expected %0d", k, n - e.cyc, lat_tab[k]);
                        end
                    end
                end
            end
            r_valid = (n < 400) && ($urandom_range(0, 4) != 0);
            r_data  = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) r_data = 64'd0;
            case ($urandom_range(0, 5))
                0:       r_ct = 6'd0;
                1:       r_ct = 6'd63;
                default: r_ct = 6'($urandom);
            endcase
            r_dir  = 1'($urandom);
            r_type = 2'($urandom);
            r_tag  = 5'($urandom);
            if (r_valid) begin
                m = ref_model(r_data, int'(r_ct), r_dir, r_type, 64);
                e = '{m[63:0], m[64], m[65], r_tag, n};
                for (int k = 0; k < 4; k++) q64[k].push_back(e);
            end
            step();
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q64[k].size() != 0) begin
                errors++;
                $display("FAIL sweep_drain[%0d]: got %0d results pending expected 0", k, q64[k].size());
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_ct_zero();
        test_max_ct();
        test_backpressure();
        test_reset_flush();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
